// File: rtl/pcie_phy_pkg.sv
// Shared PHY symbols, widths and transmit FSM encoding for the byte-to-serial path.
// P2S_IDLE_FILL_EN selects IDL instead of COM as the fill symbol in ACTIVE.
package pcie_phy_pkg;

    localparam int unsigned BYTE_W = 8;

    localparam logic [BYTE_W-1:0] K_COM = 8'hBC;
    localparam logic [BYTE_W-1:0] K_IDL = 8'h7C;

    typedef enum logic {
        SYNC   = 1'b0,
        ACTIVE = 1'b1
    } p2s_state_e;

    // Symbol sent in an ACTIVE slot that has no valid byte.
    function automatic logic [BYTE_W-1:0] fill_sym();
`ifdef P2S_IDLE_FILL_EN
        return K_IDL;
`else
        return K_COM;
`endif
    endfunction

endpackage

// File: rtl/par2serial_tx_if.sv
// Byte stream in / serial stream out bundle for par2serial_tx.
interface par2serial_tx_if;
    import pcie_phy_pkg::*;

    logic [BYTE_W-1:0] data_in;
    logic              valid_in;
    logic              take;
    logic              active;
    logic              data_out;

    modport master (
        output data_in,
        output valid_in,
        input  take,
        input  active,
        input  data_out
    );

    modport slave (
        input  data_in,
        input  valid_in,
        output take,
        output active,
        output data_out
    );

endinterface

// File: rtl/p2s_shift8.sv
// 8-bit MSB-first shifter with free-running bit counter; loads sel_i on the cnt==7 edge.
module p2s_shift8
    import pcie_phy_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [BYTE_W-1:0] sel_i,
    output logic              load_edge_o,
    output logic              data_out_o
);

    logic [2:0]        cnt_q, cnt_d;
    logic [BYTE_W-1:0] sr_q, sr_d;
    logic              dout_q, dout_d;

    // Decoded from the counter register only, so take has no input path.
    assign load_edge_o = (cnt_q == 3'd7);
    assign data_out_o  = dout_q;

    always_comb begin
        cnt_d  = cnt_q + 3'd1;
        sr_d   = {sr_q[BYTE_W-2:0], 1'b0};
        dout_d = sr_q[BYTE_W-1];
        if (load_edge_o) begin
            sr_d   = {sel_i[BYTE_W-2:0], 1'b0};
            dout_d = sel_i[BYTE_W-1];
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q  <= 3'd0;
            sr_q   <= '0;
            dout_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sr_q   <= sr_d;
            dout_q <= dout_d;
        end
    end

endmodule

// File: rtl/par2serial_tx.sv
// Parallel-to-serial transmitter: COM preamble after reset, then bytes or fill symbols MSB-first.
// Build option: P2S_IDLE_FILL_EN (fill with IDL instead of COM once ACTIVE).
module par2serial_tx
    import pcie_phy_pkg::*;
#(
    parameter int unsigned SYNC_SYMS = 4
) (
    input  logic               clk32f,
    input  logic               reset,
    par2serial_tx_if.slave     bus
);

    p2s_state_e        state_q, state_d;
    logic [3:0]        syms_q, syms_d;
    logic              load_edge;
    logic [BYTE_W-1:0] sel;

    localparam logic [3:0] LAST_SYM = 4'(SYNC_SYMS - 1);

    always_comb begin
        state_d = state_q;
        syms_d  = syms_q;
        sel     = K_COM;
        unique case (state_q)
            SYNC: begin
                // Upstream bytes are ignored until the preamble has gone out.
                if (load_edge) begin
                    syms_d = syms_q + 4'd1;
                    if (syms_q == LAST_SYM) state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                sel = bus.valid_in ? bus.data_in : fill_sym();
            end
            default: state_d = SYNC;
        endcase
    end

    always_ff @(posedge clk32f or negedge reset) begin
        if (!reset) begin
            state_q <= SYNC;
            syms_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            syms_q  <= syms_d;
        end
    end

    p2s_shift8 u_shift (
        .clk_i       (clk32f),
        .rst_n_i     (reset),
        .sel_i       (sel),
        .load_edge_o (load_edge),
        .data_out_o  (bus.data_out)
    );

    assign bus.active = (state_q == ACTIVE);
    assign bus.take   = (state_q == ACTIVE) && load_edge;

endmodule
